// File: rtl/snn_pkg.sv
// Shared definitions for the SNN readout blocks: default widths of the
// argmax node record {present, index, value} and small elaboration helpers.
package snn_pkg;

    // Ceiling log2, never below 1, so a 2-lane tree still has one level.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    localparam int SNN_VALUE_W   = 19;
    localparam int SNN_NUM_IN    = 10;
    localparam int SNN_PRESENT_W = 1;
    localparam int SNN_IDX_W     = clog2(SNN_NUM_IN);
    localparam int SNN_NODE_W    = SNN_PRESENT_W + SNN_IDX_W + SNN_VALUE_W;

    // Bit offset of a lane inside a flat bus of equal-width lanes.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/argmax_node.sv
// One registered node of the argmax reduction tree. Picks the larger of two
// children, preferring the left (lower lane) child on a tie, and ignores a
// child whose present bit is clear.
module argmax_node
    import snn_pkg::*;
#(
    parameter int p_width = SNN_VALUE_W,
    parameter int p_idx_w = SNN_IDX_W
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_flush,
    input  logic               i_left_valid,
    input  logic               i_left_present,
    input  logic [p_width-1:0] i_left_value,
    input  logic [p_idx_w-1:0] i_left_index,
    input  logic               i_right_valid,
    input  logic               i_right_present,
    input  logic [p_width-1:0] i_right_value,
    input  logic [p_idx_w-1:0] i_right_index,
    output logic               o_valid,
    output logic               o_present,
    output logic [p_width-1:0] o_value,
    output logic [p_idx_w-1:0] o_index
);

    logic               w_pickRight;
    logic               r_valid;
    logic               r_present;
    logic [p_width-1:0] r_value;
    logic [p_idx_w-1:0] r_index;

    // Right child wins only if it is present and either the left is absent or strictly larger.
    always_comb begin
        w_pickRight = 1'b0;
        if (i_right_present && (!i_left_present || (i_right_value > i_left_value))) begin
            w_pickRight = 1'b1;
        end
    end

    // Register the selected child; valid is killed by reset or flush.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid   <= 1'b0;
            r_present <= 1'b0;
            r_value   <= '0;
            r_index   <= '0;
        end else begin
            r_valid   <= i_left_valid & i_right_valid & ~i_flush;
            r_present <= i_left_present | i_right_present;
            r_value   <= w_pickRight ? i_right_value : i_left_value;
            r_index   <= w_pickRight ? i_right_index : i_left_index;
        end
    end

    assign o_valid   = r_valid;
    assign o_present = r_present;
    assign o_value   = r_value;
    assign o_index   = r_index;

endmodule

// File: rtl/argmax_tree_pipe.sv
// Pipelined N-input argmax for the SNN readout. Lanes are padded to a power
// of two and reduced by a heap-indexed binary tree of registered nodes (node
// n has children 2n and 2n+1, leaves at NLEAF..2*NLEAF-1, root at 1). The
// threshold rides a delay line alongside, and a final stage applies it.
module argmax_tree_pipe
    import snn_pkg::*;
#(
    parameter int p_width  = SNN_VALUE_W,
    parameter int p_num_in = SNN_NUM_IN,
    parameter int p_idx_w  = SNN_IDX_W
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_valid,
    input  logic [p_num_in*p_width-1:0]  i_data,
    input  logic [p_num_in-1:0]          i_mask,
    input  logic [p_width-1:0]           i_thresh,
    input  logic                         i_flush,
    output logic                         o_valid,
    output logic [p_width-1:0]           o_result,
    output logic [p_num_in-1:0]          o_index,
    output logic [p_idx_w-1:0]           o_index_bin,
    output logic                         o_hit
);

    localparam int L     = clog2(p_num_in);
    localparam int NLEAF = 1 << L;
    localparam int NNODE = 2 * NLEAF;

    logic               w_valid   [1:NNODE-1];
    logic               w_present [1:NNODE-1];
    logic [p_width-1:0] w_value   [1:NNODE-1];
    logic [p_idx_w-1:0] w_index   [1:NNODE-1];

    logic [p_num_in-1:0] w_oneHot;
    logic [p_width-1:0]  r_thrPipe [0:L-1];

    logic                r_outValid;
    logic [p_width-1:0]  r_result;
    logic [p_num_in-1:0] r_index;
    logic [p_idx_w-1:0]  r_indexBin;
    logic                r_hit;

    genvar g;

    // Leaves: real lanes take their mask bit, padding lanes are never present.
    for (g = 0; g < NLEAF; g++) begin : gLeaf
        if (g < p_num_in) begin : gReal
            assign w_present[NLEAF+g] = i_mask[g];
            assign w_value[NLEAF+g]   = i_data[lane_lsb(g, p_width) +: p_width];
        end else begin : gPad
            assign w_present[NLEAF+g] = 1'b0;
            assign w_value[NLEAF+g]   = '0;
        end
        assign w_index[NLEAF+g] = p_idx_w'(g);
        assign w_valid[NLEAF+g] = i_valid;
    end

    // Internal nodes: one register stage per tree level.
    for (g = 1; g < NLEAF; g++) begin : gNode
        argmax_node #(
            .p_width (p_width),
            .p_idx_w (p_idx_w)
        ) uNode (
            .i_clk           (i_clk),
            .i_rst_n         (i_rst_n),
            .i_flush         (i_flush),
            .i_left_valid    (w_valid[2*g]),
            .i_left_present  (w_present[2*g]),
            .i_left_value    (w_value[2*g]),
            .i_left_index    (w_index[2*g]),
            .i_right_valid   (w_valid[2*g+1]),
            .i_right_present (w_present[2*g+1]),
            .i_right_value   (w_value[2*g+1]),
            .i_right_index   (w_index[2*g+1]),
            .o_valid         (w_valid[g]),
            .o_present       (w_present[g]),
            .o_value         (w_value[g]),
            .o_index         (w_index[g])
        );
    end

    // Threshold delay line, L deep so it lines up with the root of the tree.
    always_ff @(posedge i_clk) begin
        r_thrPipe[0] <= i_thresh;
        for (int s = 1; s < L; s++) begin
            r_thrPipe[s] <= r_thrPipe[s-1];
        end
    end

    // Decode the root's binary index to one-hot over the real lanes.
    always_comb begin
        w_oneHot = '0;
        for (int k = 0; k < p_num_in; k++) begin
            if (w_index[1] == p_idx_w'(k)) begin
                w_oneHot[k] = 1'b1;
            end
        end
    end

    // Output stage: apply threshold and force everything to zero unless a present winner is valid.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_outValid <= 1'b0;
            r_result   <= '0;
            r_index    <= '0;
            r_indexBin <= '0;
            r_hit      <= 1'b0;
        end else begin
            r_outValid <= w_valid[1];
            if (w_valid[1] && w_present[1]) begin
                r_result   <= w_value[1];
                r_index    <= w_oneHot;
                r_indexBin <= w_index[1];
                r_hit      <= (w_value[1] >= r_thrPipe[L-1]);
            end else begin
                r_result   <= '0;
                r_index    <= '0;
                r_indexBin <= '0;
                r_hit      <= 1'b0;
            end
        end
    end

    assign o_valid     = r_outValid;
    assign o_result    = r_result;
    assign o_index     = r_index;
    assign o_index_bin = r_indexBin;
    assign o_hit       = r_hit;

endmodule

// File: tb/tb_argmax_tree_pipe.sv
// Self-checking bench for argmax_tree_pipe with 10 lanes of 19 bits.
// Every cycle the output is compared against a queue of expected results,
// each tagged with the cycle it must appear on.
module tb_argmax_tree_pipe;

    localparam int W   = 19;
    localparam int N   = 10;
    localparam int IW  = 5;
    localparam int LAT = 5;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_valid;
    logic [N*W-1:0]    i_data;
    logic [N-1:0]      i_mask;
    logic [W-1:0]      i_thresh;
    logic              i_flush;
    logic              o_valid;
    logic [W-1:0]      o_result;
    logic [N-1:0]      o_index;
    logic [IW-1:0]     o_index_bin;
    logic              o_hit;

    typedef struct {
        logic [W-1:0]  result;
        logic [N-1:0]  oneHot;
        logic [IW-1:0] bin;
        logic          hit;
        int            due;
    } expT;

    expT          expQ[$];
    logic [W-1:0] lanes [N];
    int           cycle  = 0;
    int           checks = 0;
    int           errors = 0;

    // Free-running clock, 10 time units per period.
    always #5 i_clk = ~i_clk;

    argmax_tree_pipe #(
        .p_width  (W),
        .p_num_in (N),
        .p_idx_w  (IW)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .i_mask      (i_mask),
        .i_thresh    (i_thresh),
        .i_flush     (i_flush),
        .o_valid     (o_valid),
        .o_result    (o_result),
        .o_index     (o_index),
        .o_index_bin (o_index_bin),
        .o_hit       (o_hit)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, actual, expected, cycle);
        end
    endtask

    task automatic monitorOutputs();
        logic expValid;
        expT  e;
        expValid = (expQ.size() > 0) && (expQ[0].due == cycle);
        checkOutput("o_valid", {63'd0, o_valid}, {63'd0, expValid});
        if (expValid) begin
            e = expQ.pop_front();
            checkOutput("o_result", 64'(o_result), 64'(e.result));
            checkOutput("o_index", 64'(o_index), 64'(e.oneHot));
            checkOutput("o_index_bin", 64'(o_index_bin), 64'(e.bin));
            checkOutput("o_hit", {63'd0, o_hit}, {63'd0, e.hit});
        end else begin
            checkOutput("idle_result", 64'(o_result), 64'd0);
            checkOutput("idle_index", 64'(o_index), 64'd0);
            checkOutput("idle_bin", 64'(o_index_bin), 64'd0);
            checkOutput("idle_hit", {63'd0, o_hit}, 64'd0);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        cycle++;
        monitorOutputs();
    endtask

    task automatic loadLanes();
        for (int k = 0; k < N; k++) begin
            i_data[k*W +: W] = lanes[k];
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] mask, input logic [W-1:0] thr,
                                 input logic [W-1:0] eRes, input logic [N-1:0] eHot,
                                 input logic [IW-1:0] eBin, input logic eHit);
        expT e;
        loadLanes();
        i_mask   = mask;
        i_thresh = thr;
        i_valid  = 1'b1;
        e.result = eRes;
        e.oneHot = eHot;
        e.bin    = eBin;
        e.hit    = eHit;
        e.due    = cycle + LAT;
        expQ.push_back(e);
        tick();
    endtask

    // Straight scan over the lanes: first strictly larger value wins, so ties keep the lowest lane.
    task automatic refModel(input logic [N-1:0] mask, input logic [W-1:0] thr,
                            output logic [W-1:0] eRes, output logic [N-1:0] eHot,
                            output logic [IW-1:0] eBin, output logic eHit);
        logic         found;
        logic [W-1:0] best;
        int           bi;
        found = 1'b0;
        best  = '0;
        bi    = 0;
        for (int k = 0; k < N; k++) begin
            if (mask[k] && (!found || lanes[k] > best)) begin
                found = 1'b1;
                best  = lanes[k];
                bi    = k;
            end
        end
        eRes = found ? best : '0;
        eHot = found ? (N'(1) << bi) : '0;
        eBin = found ? IW'(bi) : '0;
        eHit = found && (best >= thr);
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        logic [W-1:0]  eRes;
        logic [N-1:0]  eHot;
        logic [IW-1:0] eBin;
        logic          eHit;
        logic [N-1:0]  m;
        logic [W-1:0]  t;

        // Reset held three cycles with valid asserted: nothing may emerge.
        for (int k = 0; k < N; k++) lanes[k] = W'(k * 1000 + 7);
        loadLanes();
        i_rst_n  = 1'b0;
        i_valid  = 1'b1;
        i_mask   = '1;
        i_thresh = '0;
        i_flush  = 1'b0;
        repeat (3) tick();
        i_rst_n = 1'b1;
        idle(2);

        // Ascending lanes with one large lane 7.
        for (int k = 0; k < N; k++) lanes[k] = W'(k * 100);
        lanes[7] = 19'd5000;
        applyStimulus('1, 19'd1000, 19'd5000, 10'b0010000000, 5'd7, 1'b1);
        idle(6);

        // Three-way tie resolves to the lowest lane; threshold above and equal.
        for (int k = 0; k < N; k++) lanes[k] = 19'd10;
        lanes[2] = 19'd800;
        lanes[6] = 19'd800;
        lanes[9] = 19'd800;
        applyStimulus('1, 19'd900, 19'd800, 10'b0000000100, 5'd2, 1'b0);
        applyStimulus('1, 19'd800, 19'd800, 10'b0000000100, 5'd2, 1'b1);

        // Masked maximum is skipped; fully masked vector gives a valid empty result.
        for (int k = 0; k < N; k++) lanes[k] = W'(k * 10);
        lanes[1] = 19'd300;
        lanes[4] = 19'd9999;
        applyStimulus(10'b1111101111, 19'd100, 19'd300, 10'b0000000010, 5'd1, 1'b1);
        applyStimulus(10'b0000000000, 19'd0, 19'd0, 10'b0000000000, 5'd0, 1'b0);

        // Full-scale value on the last lane, and all-zero data with zero threshold.
        for (int k = 0; k < N; k++) lanes[k] = 19'd5;
        lanes[9] = 19'h7FFFF;
        applyStimulus('1, 19'h7FFFF, 19'h7FFFF, 10'b1000000000, 5'd9, 1'b1);
        for (int k = 0; k < N; k++) lanes[k] = 19'd0;
        applyStimulus('1, 19'd0, 19'd0, 10'b0000000001, 5'd0, 1'b1);
        idle(6);

        // Twenty back-to-back vectors, half with narrow values to force ties.
        for (int v = 0; v < 20; v++) begin
            for (int k = 0; k < N; k++) begin
                lanes[k] = (v % 2 == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            end
            m = N'($urandom) | N'($urandom);
            t = (v % 2 == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            refModel(m, t, eRes, eHot, eBin, eHit);
            applyStimulus(m, t, eRes, eHot, eBin, eHit);
        end
        idle(6);

        // Flush with four samples in flight; the sample presented with flush is dropped too.
        for (int k = 0; k < N; k++) lanes[k] = W'(k + 1);
        for (int v = 0; v < 4; v++) begin
            applyStimulus('1, 19'd0, 19'd10, 10'b1000000000, 5'd9, 1'b1);
        end
        expQ.delete();
        i_flush = 1'b1;
        i_valid = 1'b1;
        tick();
        i_flush = 1'b0;
        idle(7);

        // Reset pulse with four samples in flight, then one fresh sample.
        for (int v = 0; v < 4; v++) begin
            applyStimulus('1, 19'd0, 19'd10, 10'b1000000000, 5'd9, 1'b1);
        end
        expQ.delete();
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        tick();
        i_rst_n = 1'b1;
        for (int k = 0; k < N; k++) lanes[k] = W'(50 - k);
        applyStimulus('1, 19'd51, 19'd50, 10'b0000000001, 5'd0, 1'b0);
        idle(8);

        checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
